// File: rtl/scan_reg_pkg.sv
// scan_reg_pkg: shared sizes and FSM state type for the scan register bank
package scan_reg_pkg;
    localparam int NUM_ENTRIES = 16;
    localparam int CR_W = 17;
    localparam int SR_W = 15;
    localparam int IDX_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} reg_state_t;
endpackage

// File: rtl/sticky_status_reg.sv
// sticky_status_reg: sticky status word; set bits accumulate, clr strobe clears, set wins over clear
//   clk, rst : clock, sync active-high reset
//   set      : per-bit set pulses
//   clr      : clear strobe for the whole word
//   q        : current status
module sticky_status_reg
    import scan_reg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [SR_W-1:0] set,
    input  logic            clr,
    output logic [SR_W-1:0] q
);
    always_ff @(posedge clk)
        q <= rst ? '0 : (q & ~{SR_W{clr}}) | set;
endmodule

// File: rtl/scan_reg_bank.sv
// scan_reg_bank: 16 control + 16 sticky status registers answering scan register requests
//   clk, rst           : clock, sync active-high reset
//   reg_wen, reg_ren   : level requests held until reg_ready (write wins if both)
//   seg_id, id_sel     : index = {id_sel, seg_id[2:0]}
//   cr_wdata           : control write data
//   cr_rdata, sr_rdata : response data, valid with reg_ready and held afterwards
//   reg_ready          : one-cycle completion pulse
//   cr_out             : live control registers, entry i at [17i+16:17i]
//   sr_set             : per-entry status set pulses, entry i at [15i+14:15i]
module scan_reg_bank
    import scan_reg_pkg::*;
#(
    parameter int              LATENCY  = 2,
    parameter logic [CR_W-1:0] CR_RESET = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        reg_wen,
    input  logic                        reg_ren,
    input  logic [3:0]                  seg_id,
    input  logic                        id_sel,
    input  logic [CR_W-1:0]             cr_wdata,
    output logic [CR_W-1:0]             cr_rdata,
    output logic [SR_W-1:0]             sr_rdata,
    output logic                        reg_ready,
    output logic [NUM_ENTRIES*CR_W-1:0] cr_out,
    input  logic [NUM_ENTRIES*SR_W-1:0] sr_set
);
    reg_state_t state, state_nxt;
    logic [3:0] cnt;
    logic [IDX_W-1:0] cap_idx;
    logic cap_wr;
    logic [CR_W-1:0] cap_wdata;
    logic [CR_W-1:0] cr [NUM_ENTRIES];
    logic [SR_W-1:0] sr [NUM_ENTRIES];
    logic req, fire;
    logic unused_seg_msb;
    assign unused_seg_msb = seg_id[3];
    assign req = reg_wen | reg_ren;
    // the access executes on the last BUSY edge so reg_ready lands LATENCY edges after capture
    assign fire = (state == BUSY) && (cnt == '0);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req ? BUSY : IDLE;
            BUSY:    state_nxt = (cnt == '0) ? RESP : BUSY;
            RESP:    state_nxt = HOLD;
            HOLD:    state_nxt = req ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_wr    <= 1'b0;
            cap_wdata <= '0;
            reg_ready <= 1'b0;
            cr_rdata  <= '0;
            sr_rdata  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) cr[i] <= CR_RESET;
        end else begin
            state     <= state_nxt;
            reg_ready <= fire;
            if (state == IDLE && req) begin
                cap_idx   <= {id_sel, seg_id[2:0]};
                cap_wr    <= reg_wen;
                cap_wdata <= cr_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                cr_rdata <= cap_wr ? cap_wdata : cr[cap_idx];
                sr_rdata <= sr[cap_idx];
                if (cap_wr) cr[cap_idx] <= cap_wdata;
            end
        end
    end
    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        sticky_status_reg u_sr (
            .clk (clk),
            .rst (rst),
            .set (sr_set[i*SR_W +: SR_W]),
            .clr (fire && !cap_wr && cap_idx == IDX_W'(i)),
            .q   (sr[i])
        );
        assign cr_out[i*CR_W +: CR_W] = cr[i];
    end
endmodule

// File: tb/tb_scan_reg_bank.sv
// tb_scan_reg_bank: directed self-checking bench for scan_reg_bank
module tb_scan_reg_bank;
    import scan_reg_pkg::*;
    localparam int LAT = 2;
    localparam logic [16:0] CRR = 17'h1_0000;

    logic clk, rst, reg_wen, reg_ren, id_sel, reg_ready;
    logic [3:0] seg_id;
    logic [16:0] cr_wdata, cr_rdata;
    logic [14:0] sr_rdata;
    logic [271:0] cr_out;
    logic [239:0] sr_set;

    int n_chk = 0;
    int n_fail = 0;
    int lat, n_rdy;
    logic [16:0] crd;
    logic [14:0] srd;
    logic [271:0] exp_cr;

    scan_reg_bank #(.LATENCY(LAT), .CR_RESET(CRR)) dut (
        .clk(clk), .rst(rst), .reg_wen(reg_wen), .reg_ren(reg_ren),
        .seg_id(seg_id), .id_sel(id_sel), .cr_wdata(cr_wdata),
        .cr_rdata(cr_rdata), .sr_rdata(sr_rdata), .reg_ready(reg_ready),
        .cr_out(cr_out), .sr_set(sr_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int idx, input logic [14:0] v);
        @(posedge clk); #1;
        sr_set = '0;
        sr_set[idx*15 +: 15] = v;
        @(posedge clk); #1;
        sr_set = '0;
    endtask

    // pv is applied for the cycle ending on the access's execute edge
    task automatic access(input logic w, input logic r, input logic [3:0] idx,
                          input logic [16:0] d, input logic [239:0] pv,
                          output int l, output logic [16:0] c, output logic [14:0] s);
        @(posedge clk); #1;
        reg_wen = w;
        reg_ren = r;
        id_sel = idx[3];
        seg_id = {~idx[3], idx[2:0]};
        cr_wdata = d;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
            sr_set = (l == LAT) ? pv : '0;
        end while (!reg_ready && l < 20);
        c = cr_rdata;
        s = sr_rdata;
        reg_wen = 1'b0;
        reg_ren = 1'b0;
        sr_set = '0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; reg_wen = 1'b0; reg_ren = 1'b0; id_sel = 1'b0;
        seg_id = '0; cr_wdata = '0; sr_set = '0;
        repeat (3) @(posedge clk);
        #1;
        exp_cr = {16{CRR}};
        check("rst_cr_out", cr_out, exp_cr);
        check("rst_ready", 272'(reg_ready), 272'(0));
        check("rst_cr_rdata", 272'(cr_rdata), 272'(0));
        check("rst_sr_rdata", 272'(sr_rdata), 272'(0));
        rst = 1'b0;

        access(1'b1, 1'b0, 4'd11, 17'h0_ABCD, '0, lat, crd, srd);
        exp_cr[11*17 +: 17] = 17'h0_ABCD;
        check("wr11_latency", 272'(lat), 272'(LAT + 1));
        check("wr11_cr_rdata", 272'(crd), 272'(17'h0_ABCD));
        check("wr11_sr_rdata", 272'(srd), 272'(0));
        check("wr11_cr_out", cr_out, exp_cr);

        access(1'b0, 1'b1, 4'd11, 17'h1_FFFF, '0, lat, crd, srd);
        check("rd11_latency", 272'(lat), 272'(LAT + 1));
        check("rd11_cr_rdata", 272'(crd), 272'(17'h0_ABCD));
        check("rd11_cr_out", cr_out, exp_cr);

        pulse(5, 15'h0011);
        access(1'b0, 1'b1, 4'd5, '0, '0, lat, crd, srd);
        check("rd5_cr_rdata", 272'(crd), 272'(CRR));
        check("rd5_sr_rdata", 272'(srd), 272'(15'h0011));
        access(1'b0, 1'b1, 4'd5, '0, '0, lat, crd, srd);
        check("rd5_again_sr", 272'(srd), 272'(0));

        pulse(2, 15'h0001);
        access(1'b0, 1'b1, 4'd2, '0, 240'(15'h0004) << 30, lat, crd, srd);
        check("rd2_race_sr", 272'(srd), 272'(15'h0001));
        access(1'b0, 1'b1, 4'd2, '0, '0, lat, crd, srd);
        check("rd2_set_wins", 272'(srd), 272'(15'h0004));
        access(1'b0, 1'b1, 4'd2, '0, '0, lat, crd, srd);
        check("rd2_cleared", 272'(srd), 272'(0));

        @(posedge clk); #1;
        reg_ren = 1'b1; id_sel = 1'b0; seg_id = 4'd0;
        n_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (reg_ready) n_rdy++;
        end
        reg_ren = 1'b0;
        check("hold_one_pulse", 272'(n_rdy), 272'(1));
        repeat (3) @(posedge clk);
        access(1'b0, 1'b1, 4'd0, '0, '0, lat, crd, srd);
        check("after_hold_latency", 272'(lat), 272'(LAT + 1));
        check("after_hold_cr", 272'(crd), 272'(CRR));

        pulse(4, 15'h0100);
        access(1'b1, 1'b1, 4'd4, 17'h0_1234, '0, lat, crd, srd);
        exp_cr[4*17 +: 17] = 17'h0_1234;
        check("both_cr_rdata", 272'(crd), 272'(17'h0_1234));
        check("both_sr_rdata", 272'(srd), 272'(15'h0100));
        check("both_cr_out", cr_out, exp_cr);
        access(1'b0, 1'b1, 4'd4, '0, '0, lat, crd, srd);
        check("rd4_cr_rdata", 272'(crd), 272'(17'h0_1234));
        check("rd4_no_clear_on_wr", 272'(srd), 272'(15'h0100));

        @(posedge clk); #1;
        reg_wen = 1'b1; id_sel = 1'b0; seg_id = 4'd7; cr_wdata = 17'h1_FFFF;
        @(posedge clk); #1;
        rst = 1'b1;
        reg_wen = 1'b0;
        n_rdy = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (reg_ready) n_rdy++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (reg_ready) n_rdy++;
        end
        exp_cr = {16{CRR}};
        check("abort_no_ready", 272'(n_rdy), 272'(0));
        check("abort_cr_out", cr_out, exp_cr);
        check("abort_cr_rdata", 272'(cr_rdata), 272'(0));
        access(1'b0, 1'b1, 4'd7, '0, '0, lat, crd, srd);
        check("abort_idle_latency", 272'(lat), 272'(LAT + 1));
        check("abort_rd7_cr", 272'(crd), 272'(CRR));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
